ps2_key_decoder: RTL and testbench

Consumes the raw scan-code byte stream from the PS/2 interface (`scan_code` plus the one-cycle `scan_ready` strobe) and turns it into game controls. It parses set-2 prefixes (E0 extended, F0 break, E1 pause sequence) and tracks held state for the four paddle keys. It drives level paddle-direction outputs and a one-shot start pulse to the Pong game logic. It sits directly downstream of the PS/2 interface and upstream of the paddle/ball controller.

---
 rtl/ps2_key_decoder_if.sv | 38 +++
 rtl/ps2_key_decoder.sv | 204 ++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if
// Groups the byte stream coming from the PS/2 receiver together with the
// decoded game-control outputs that go to the paddle/ball controller.
//   scan_code   [7:0]  byte from the PS/2 receiver, valid while scan_ready=1
//   scan_ready         one-cycle strobe per received byte
//   p1_up/p1_down      resolved player-1 paddle direction levels
//   p2_up/p2_down      resolved player-2 paddle direction levels
//   start_pulse        one-cycle pulse on a fresh start-key press
//   key_event          one-cycle pulse per decoded non-prefix code
//   last_code   [7:0]  final byte of the last decoded code
//   last_break         last decoded code was a release
//   last_ext           last decoded code carried the E0 prefix
// master: byte source / control consumer side; slave: the decoder.
interface ps2_key_decoder_if;
    logic [7:0] scan_code;
    logic       scan_ready;
    logic       p1_up;
    logic       p1_down;
    logic       p2_up;
    logic       p2_down;
    logic       start_pulse;
    logic       key_event;
    logic [7:0] last_code;
    logic       last_break;
    logic       last_ext;

    modport master (
        output scan_code, scan_ready,
        input  p1_up, p1_down, p2_up, p2_down,
        input  start_pulse, key_event, last_code, last_break, last_ext
    );

    modport slave (
        input  scan_code, scan_ready,
        output p1_up, p1_down, p2_up, p2_down,
        output start_pulse, key_event, last_code, last_break, last_ext
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
// Parses the PS/2 set-2 scan-code stream (E0 extended, F0 break, E1 pause)
// into held state for the four paddle keys plus the start key, and drives
// paddle direction levels and a one-shot start pulse.
// Ports:
//   CLOCK_50   system clock, all state on the rising edge
//   reset      asynchronous active-high reset, clears all state
//   bus        ps2_key_decoder_if.slave (byte stream in, controls out)
// Optional feature: define PS2_DEC_TIMEOUT_EN to drop a pending prefix after
// TIMEOUT_CYCLES idle cycles. Without it the prefix states wait forever.
//
// state   | meaning
// IDLE    | no prefix pending
// EXT     | E0 seen
// BRK     | F0 seen
// EXT_BRK | E0 F0 seen
// PAUSE   | E1 seen, skipping the rest of the pause sequence
module ps2_key_decoder #(
    parameter logic [7:0] KEY_P1_UP = 8'h1D,
    parameter logic [7:0] KEY_P1_DN = 8'h1B,
    parameter logic [7:0] KEY_P2_UP = 8'h75,
    parameter logic [7:0] KEY_P2_DN = 8'h72,
`ifdef PS2_DEC_TIMEOUT_EN
    parameter logic [7:0] KEY_START = 8'h29,
    parameter int unsigned TIMEOUT_CYCLES = 2500000
`else
    parameter logic [7:0] KEY_START = 8'h29
`endif
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    ps2_key_decoder_if.slave   bus
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] EXT     = 3'd1;
    localparam logic [2:0] BRK     = 3'd2;
    localparam logic [2:0] EXT_BRK = 3'd3;
    localparam logic [2:0] PAUSE   = 3'd4;

    // E1 14 77 E1 F0 14 F0 77: seven bytes follow the leading E1
    localparam logic [2:0] PAUSE_TAIL = 3'd7;

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic [2:0] r_skip;
    logic [2:0] w_skip_nxt;

    logic       w_ctrl;
    logic       w_dec;
    logic       w_dec_brk;
    logic       w_dec_ext;
    logic       w_timeout;

    logic       r_h1u, r_h1d, r_h2u, r_h2d, r_hst;
    logic       r_start_pulse;
    logic       r_key_event;
    logic [7:0] r_last_code;
    logic       r_last_break;
    logic       r_last_ext;

    // Keyboard housekeeping bytes never start or complete a key code
    always_comb begin
        w_ctrl = 1'b0;
        case (bus.scan_code)
            8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE: w_ctrl = 1'b1;
            default:                           w_ctrl = 1'b0;
        endcase
    end

`ifdef PS2_DEC_TIMEOUT_EN
    localparam logic [21:0] TIMEOUT_LAST = 22'(TIMEOUT_CYCLES - 1);

    logic [21:0] r_idle_cnt;

    assign w_timeout = (r_state != IDLE) && !bus.scan_ready &&
                       (r_idle_cnt == TIMEOUT_LAST);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_idle_cnt <= '0;
        end else if (bus.scan_ready || (r_state == IDLE) || w_timeout) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 22'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_skip_nxt  = r_skip;
        w_dec       = 1'b0;
        w_dec_brk   = 1'b0;
        w_dec_ext   = 1'b0;
        if (bus.scan_ready) begin
            if (r_state == PAUSE) begin
                // Control bytes are part of the pause byte count here
                w_skip_nxt = r_skip - 3'd1;
                if (r_skip <= 3'd1) begin
                    w_skip_nxt  = 3'd0;
                    w_state_nxt = IDLE;
                end
            end else if (w_ctrl) begin
                w_state_nxt = IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.scan_code == 8'hE0) begin
                            w_state_nxt = EXT;
                        end else if (bus.scan_code == 8'hF0) begin
                            w_state_nxt = BRK;
                        end else if (bus.scan_code == 8'hE1) begin
                            w_state_nxt = PAUSE;
                            w_skip_nxt  = PAUSE_TAIL;
                        end else begin
                            w_dec = 1'b1;
                        end
                    end
                    EXT: begin
                        if (bus.scan_code == 8'hF0) begin
                            w_state_nxt = EXT_BRK;
                        end else if (bus.scan_code != 8'hE0) begin
                            w_dec       = 1'b1;
                            w_dec_ext   = 1'b1;
                            w_state_nxt = IDLE;
                        end
                    end
                    BRK: begin
                        w_dec       = 1'b1;
                        w_dec_brk   = 1'b1;
                        w_state_nxt = IDLE;
                    end
                    EXT_BRK: begin
                        w_dec       = 1'b1;
                        w_dec_brk   = 1'b1;
                        w_dec_ext   = 1'b1;
                        w_state_nxt = IDLE;
                    end
                    default: w_state_nxt = IDLE;
                endcase
            end
        end else if (w_timeout) begin
            w_state_nxt = IDLE;
            w_skip_nxt  = 3'd0;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_skip  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_skip  <= w_skip_nxt;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_h1u         <= 1'b0;
            r_h1d         <= 1'b0;
            r_h2u         <= 1'b0;
            r_h2d         <= 1'b0;
            r_hst         <= 1'b0;
            r_start_pulse <= 1'b0;
            r_key_event   <= 1'b0;
            r_last_code   <= 8'h00;
            r_last_break  <= 1'b0;
            r_last_ext    <= 1'b0;
        end else begin
            r_key_event   <= w_dec;
            r_start_pulse <= 1'b0;
            if (w_dec) begin
                r_last_code  <= bus.scan_code;
                r_last_break <= w_dec_brk;
                r_last_ext   <= w_dec_ext;
                if (bus.scan_code == KEY_P1_UP && !w_dec_ext) r_h1u <= !w_dec_brk;
                if (bus.scan_code == KEY_P1_DN && !w_dec_ext) r_h1d <= !w_dec_brk;
                if (bus.scan_code == KEY_P2_UP &&  w_dec_ext) r_h2u <= !w_dec_brk;
                if (bus.scan_code == KEY_P2_DN &&  w_dec_ext) r_h2d <= !w_dec_brk;
                if (bus.scan_code == KEY_START && !w_dec_ext) begin
                    r_hst <= !w_dec_brk;
                    // typematic repeats arrive with hst already set
                    r_start_pulse <= !w_dec_brk && !r_hst;
                end
            end
        end
    end

    // Opposing keys held together cancel out
    assign bus.p1_up       = r_h1u & ~r_h1d;
    assign bus.p1_down     = r_h1d & ~r_h1u;
    assign bus.p2_up       = r_h2u & ~r_h2d;
    assign bus.p2_down     = r_h2d & ~r_h2u;
    assign bus.start_pulse = r_start_pulse;
    assign bus.key_event   = r_key_event;
    assign bus.last_code   = r_last_code;
    assign bus.last_break  = r_last_break;
    assign bus.last_ext    = r_last_ext;

endmodule

// File: tb/tb_ps2_key_decoder.sv
module tb_ps2_key_decoder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ps2_key_decoder_if bus();

`ifdef PS2_DEC_TIMEOUT_EN
    localparam int TMO = 40;
    ps2_key_decoder #(.TIMEOUT_CYCLES(TMO)) dut (.CLOCK_50(clk), .reset(rst), .bus(bus));
`else
    ps2_key_decoder dut (.CLOCK_50(clk), .reset(rst), .bus(bus));
`endif

    int n_pass  = 0;
    int n_total = 0;

    // packed view: {p1u,p1d,p2u,p2d,start,kev,last_code[7:0],last_break,last_ext}
    function automatic logic [14:0] ev(input bit p1u, input bit p1d, input bit p2u,
                                       input bit p2d, input bit st, input bit kev,
                                       input logic [7:0] lc, input bit lb, input bit le);
        return {p1u, p1d, p2u, p2d, st, kev, lc, lb, le};
    endfunction

    function automatic logic [14:0] dut_vec();
        return {bus.p1_up, bus.p1_down, bus.p2_up, bus.p2_down, bus.start_pulse,
                bus.key_event, bus.last_code, bus.last_break, bus.last_ext};
    endfunction

    task automatic check(input string name, input logic [14:0] exp);
        logic [14:0] act;
        act = dut_vec();
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (p1u p1d p2u p2d st kev code brk ext)",
                      name, act, exp);
    endtask

    task automatic step(input logic [7:0] code, input logic rdy);
        @(negedge clk);
        bus.scan_code  = code;
        bus.scan_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.scan_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // ---------------- reference model ----------------
    logic [7:0] mq[$];
    bit         mh[5];
    bit         m_kev, m_st, m_lb, m_le;
    logic [7:0] m_lc;
    logic [7:0] key_code[5] = '{8'h1D, 8'h1B, 8'h75, 8'h72, 8'h29};
    bit         key_ext[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    task automatic model_reset();
        mq.delete();
        foreach (mh[k]) mh[k] = 1'b0;
        m_kev = 0; m_st = 0; m_lb = 0; m_le = 0; m_lc = 8'h00;
    endtask

    function automatic bit is_ctrl(input logic [7:0] b);
        return b == 8'h00 || b == 8'hFF || b == 8'hAA || b == 8'hFA || b == 8'hFE;
    endfunction

    task automatic model_decode(input logic [7:0] b, input bit brk, input bit ext);
        m_kev = 1; m_lc = b; m_lb = brk; m_le = ext;
        for (int k = 0; k < 5; k++) begin
            if (b == key_code[k] && ext == key_ext[k]) begin
                if (k == 4 && !brk && !mh[4]) m_st = 1;
                mh[k] = !brk;
            end
        end
    endtask

    task automatic model_byte(input logic [7:0] b, input bit rdy);
        bit has_e0, has_f0;
        m_kev = 0; m_st = 0;
        if (!rdy) return;
        if (mq.size() > 0 && mq[0] == 8'hE1) begin
            mq.push_back(b);
            if (mq.size() == 8) mq.delete();
            return;
        end
        if (is_ctrl(b)) begin
            mq.delete();
            return;
        end
        has_e0 = 0; has_f0 = 0;
        foreach (mq[i]) begin
            if (mq[i] == 8'hE0) has_e0 = 1;
            if (mq[i] == 8'hF0) has_f0 = 1;
        end
        if (mq.size() == 0) begin
            if (b == 8'hE0 || b == 8'hF0 || b == 8'hE1) mq.push_back(b);
            else model_decode(b, 0, 0);
        end else if (has_f0) begin
            model_decode(b, 1, has_e0);
            mq.delete();
        end else if (b == 8'hF0 || b == 8'hE0) begin
            mq.push_back(b);
        end else begin
            model_decode(b, 0, 1);
            mq.delete();
        end
    endtask

    function automatic logic [14:0] model_vec();
        return ev(mh[0] & ~mh[1], mh[1] & ~mh[0], mh[2] & ~mh[3], mh[3] & ~mh[2],
                  m_st, m_kev, m_lc, m_lb, m_le);
    endfunction

    // ---------------- directed table ----------------
    typedef struct {
        logic [7:0]  code;
        logic        rdy;
        logic [14:0] exp;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic [7:0] code, input logic rdy, input logic [14:0] exp);
        vec_t v;
        v.code = code; v.rdy = rdy; v.exp = exp;
        tbl.push_back(v);
    endtask

    logic [7:0] pick[13] = '{8'h1D, 8'h1B, 8'h75, 8'h72, 8'h29, 8'hE0, 8'hF0,
                             8'hE1, 8'h00, 8'hFA, 8'hFE, 8'hAA, 8'hFF};

    initial begin
        rst = 1'b1;
        bus.scan_code  = 8'h00;
        bus.scan_ready = 1'b0;

        //    code   rdy  p1u p1d p2u p2d st kev code  brk ext
        add(8'h1D, 1, ev(1, 0, 0, 0, 0, 1, 8'h1D, 0, 0));
        add(8'h00, 0, ev(1, 0, 0, 0, 0, 0, 8'h1D, 0, 0));
        add(8'hF0, 1, ev(1, 0, 0, 0, 0, 0, 8'h1D, 0, 0));
        add(8'h1D, 1, ev(0, 0, 0, 0, 0, 1, 8'h1D, 1, 0));
        add(8'hE0, 1, ev(0, 0, 0, 0, 0, 0, 8'h1D, 1, 0));
        add(8'h75, 1, ev(0, 0, 1, 0, 0, 1, 8'h75, 0, 1));
        add(8'hE0, 1, ev(0, 0, 1, 0, 0, 0, 8'h75, 0, 1));
        add(8'hF0, 1, ev(0, 0, 1, 0, 0, 0, 8'h75, 0, 1));
        add(8'h75, 1, ev(0, 0, 0, 0, 0, 1, 8'h75, 1, 1));
        add(8'h75, 1, ev(0, 0, 0, 0, 0, 1, 8'h75, 0, 0));
        add(8'h1D, 1, ev(1, 0, 0, 0, 0, 1, 8'h1D, 0, 0));
        add(8'h1B, 1, ev(0, 0, 0, 0, 0, 1, 8'h1B, 0, 0));
        add(8'hF0, 1, ev(0, 0, 0, 0, 0, 0, 8'h1B, 0, 0));
        add(8'h1D, 1, ev(0, 1, 0, 0, 0, 1, 8'h1D, 1, 0));
        add(8'hF0, 1, ev(0, 1, 0, 0, 0, 0, 8'h1D, 1, 0));
        add(8'h1B, 1, ev(0, 0, 0, 0, 0, 1, 8'h1B, 1, 0));
        add(8'h29, 1, ev(0, 0, 0, 0, 1, 1, 8'h29, 0, 0));
        add(8'h29, 1, ev(0, 0, 0, 0, 0, 1, 8'h29, 0, 0));
        add(8'h29, 1, ev(0, 0, 0, 0, 0, 1, 8'h29, 0, 0));
        add(8'hF0, 1, ev(0, 0, 0, 0, 0, 0, 8'h29, 0, 0));
        add(8'h29, 1, ev(0, 0, 0, 0, 0, 1, 8'h29, 1, 0));
        add(8'h29, 1, ev(0, 0, 0, 0, 1, 1, 8'h29, 0, 0));
        add(8'hE1, 1, ev(0, 0, 0, 0, 0, 0, 8'h29, 0, 0));
        add(8'h14, 1, ev(0, 0, 0, 0, 0, 0, 8'h29, 0, 0));
        add(8'h77, 1, ev(0, 0, 0, 0, 0, 0, 8'h29, 0, 0));
        add(8'hE1, 1, ev(0, 0, 0, 0, 0, 0, 8'h29, 0, 0));
        add(8'hF0, 1, ev(0, 0, 0, 0, 0, 0, 8'h29, 0, 0));
        add(8'h14, 1, ev(0, 0, 0, 0, 0, 0, 8'h29, 0, 0));
        add(8'hF0, 1, ev(0, 0, 0, 0, 0, 0, 8'h29, 0, 0));
        add(8'h77, 1, ev(0, 0, 0, 0, 0, 0, 8'h29, 0, 0));
        add(8'h1D, 1, ev(1, 0, 0, 0, 0, 1, 8'h1D, 0, 0));
        add(8'hFA, 1, ev(1, 0, 0, 0, 0, 0, 8'h1D, 0, 0));
        add(8'hE0, 1, ev(1, 0, 0, 0, 0, 0, 8'h1D, 0, 0));
        add(8'hFE, 1, ev(1, 0, 0, 0, 0, 0, 8'h1D, 0, 0));
        add(8'h75, 1, ev(1, 0, 0, 0, 0, 1, 8'h75, 0, 0));
        add(8'hF0, 1, ev(1, 0, 0, 0, 0, 0, 8'h75, 0, 0));
        add(8'h1D, 1, ev(0, 0, 0, 0, 0, 1, 8'h1D, 1, 0));

        do_reset();
        check("reset_state", ev(0, 0, 0, 0, 0, 0, 8'h00, 0, 0));

        foreach (tbl[i]) begin
            step(tbl[i].code, tbl[i].rdy);
            check($sformatf("table[%0d]", i), tbl[i].exp);
        end

        // reset in the middle of an E0 prefix clears at once
        do_reset();
        step(8'h1D, 1);
        step(8'hE0, 1);
        @(negedge clk);
        bus.scan_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("async_reset_clear", ev(0, 0, 0, 0, 0, 0, 8'h00, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        step(8'h72, 1);
        check("after_reset_72", ev(0, 0, 0, 0, 0, 1, 8'h72, 0, 0));

`ifdef PS2_DEC_TIMEOUT_EN
        do_reset();
        step(8'hE0, 1);
        repeat (TMO + 1) step(8'h00, 0);
        step(8'h75, 1);
        check("timeout_drops_e0", ev(0, 0, 0, 0, 0, 1, 8'h75, 0, 0));
`endif

        // randomized stream against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [7:0] b;
            bit         r;
            if ($urandom_range(0, 15) < 13) b = pick[$urandom_range(0, 12)];
            else b = 8'($urandom_range(0, 255));
            r = ($urandom_range(0, 3) != 0);
            step(b, r);
            model_byte(b, r);
            check($sformatf("random[%0d] byte %h rdy %0d", c, b, r), model_vec());
        end

        bus.scan_ready = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
